// File: rtl/wisc_pkg.sv
// wisc_pkg: ISA-wide constants and types shared by the control-flow and decode logic
package wisc_pkg;
  localparam int ADDR_W = 16;
  localparam logic [2:0] COND_NEQ    = 3'b000;
  localparam logic [2:0] COND_EQ     = 3'b001;
  localparam logic [2:0] COND_GT     = 3'b010;
  localparam logic [2:0] COND_LT     = 3'b011;
  localparam logic [2:0] COND_GTE    = 3'b100;
  localparam logic [2:0] COND_LTE    = 3'b101;
  localparam logic [2:0] COND_OVFL   = 3'b110;
  localparam logic [2:0] COND_UNCOND = 3'b111;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} halt_state_t;
endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: decides whether a branch condition holds for the given Z/V/N flags
module branch_cond_eval
  import wisc_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       z,
  input  logic       v,
  input  logic       n,
  output logic       taken
);
  always_comb
    taken = cond == COND_NEQ  ? !z :
            cond == COND_EQ   ? z :
            cond == COND_GT   ? (!z && !n) :
            cond == COND_LT   ? n :
            cond == COND_GTE  ? !n :
            cond == COND_LTE  ? (n || z) :
            cond == COND_OVFL ? v : 1'b1;
endmodule

// File: rtl/flow_control_unit.sv
// flow_control_unit: branch/JAL/JR resolution, load-use stalls, flag register and halt sequencing
module flow_control_unit
  import wisc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_ID_EX,
  input  logic              is_br_ID_EX,
  input  logic              is_jal_ID_EX,
  input  logic              is_jr_ID_EX,
  input  logic              is_hlt_ID_EX,
  input  logic [2:0]        cond_ID_EX,
  input  logic [8:0]        br_off_ID_EX,
  input  logic [11:0]       jal_off_ID_EX,
  input  logic [ADDR_W-1:0] jr_tgt_ID_EX,
  input  logic [ADDR_W-1:0] pc_ID_EX,
  input  logic              set_flags_EX,
  input  logic              alu_z,
  input  logic              alu_v,
  input  logic              alu_n,
  input  logic              mem_rd_ID_EX,
  input  logic [3:0]        rd_ID_EX,
  input  logic [3:0]        rs_IF_ID,
  input  logic [3:0]        rt_IF_ID,
  input  logic              rs_used_IF_ID,
  input  logic              rt_used_IF_ID,
  output logic              flow_change_ID_EX,
  output logic [ADDR_W-1:0] dst_ID_EX,
  output logic              stall,
  output logic              flush_IF_ID,
  output logic              flush_ID_EX,
  output logic              hlt,
  output logic [2:0]        flags
);
  halt_state_t state;
  logic [1:0] cnt;
  logic run, taken, halt_start, load_use;
  logic [ADDR_W-1:0] br_tgt, jal_tgt;
  branch_cond_eval u_cond (
    .cond (cond_ID_EX),
    .z    (flags[FLAG_Z]),
    .v    (flags[FLAG_V]),
    .n    (flags[FLAG_N]),
    .taken(taken)
  );
  always_comb begin
    run = state == RUN;
    br_tgt = pc_ID_EX + {{7{br_off_ID_EX[8]}}, br_off_ID_EX};
    jal_tgt = pc_ID_EX + {{4{jal_off_ID_EX[11]}}, jal_off_ID_EX};
    flow_change_ID_EX = valid_ID_EX && run && ((is_br_ID_EX && taken) || is_jal_ID_EX || is_jr_ID_EX);
    dst_ID_EX = !flow_change_ID_EX ? '0 :
                is_br_ID_EX ? br_tgt :
                is_jal_ID_EX ? jal_tgt : jr_tgt_ID_EX;
    halt_start = valid_ID_EX && run && is_hlt_ID_EX;
    // R0 is hardwired to zero, so a load targeting it can never create a hazard
    load_use = valid_ID_EX && run && mem_rd_ID_EX && rd_ID_EX != 4'd0 &&
               ((rd_ID_EX == rs_IF_ID && rs_used_IF_ID) || (rd_ID_EX == rt_IF_ID && rt_used_IF_ID));
    stall = !flow_change_ID_EX && (load_use || halt_start || !run);
    flush_IF_ID = flow_change_ID_EX || halt_start;
    flush_ID_EX = flow_change_ID_EX || load_use || halt_start || state == DRAIN;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= RUN;
      flags <= '0;
      cnt <= '0;
      hlt <= 1'b0;
    end else begin
      if (valid_ID_EX && set_flags_EX && run) flags <= {alu_z, alu_v, alu_n};
      case (state)
        RUN: if (halt_start) begin
          state <= DRAIN;
          cnt <= 2'd2;
        end
        DRAIN: begin
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1) begin
            state <= HALTED;
            hlt <= 1'b1;
          end
        end
        default: hlt <= 1'b1;
      endcase
    end
endmodule
